// File: rtl/pfiform_pop_reader.sv
// rtl/pfiform_pop_reader.sv - PFIFORM pop master that serialises popped words into a framed byte stream
// Optional POP_READER_STATS_EN adds stall and accepted-word counters.
module pfiform_pop_reader #(
  parameter int DATA_W  = 256,
  parameter int DEPTH   = 4,
  parameter int POP_LAT = 2
) (
  input  logic              i_core_clk,
  input  logic              i_rx_rstn,
  input  logic              i_start,
  input  logic [4:0]        i_pop_amount,
  input  logic [15:0]       i_num_pops,
  output logic              PopPermit,
  output logic [4:0]        PopAmout,
  input  logic              PopEnable,
  input  logic [DATA_W-1:0] PopData,
  output logic [7:0]        o_byte,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
`ifdef POP_READER_STATS_EN
  ,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_word_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DATA_W);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic              state_q, state_d;
  logic [4:0]        amt_q, amt_d;
  logic [15:0]       npops_q, npops_d;
  logic [15:0]       rcvd_q, rcvd_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [4:0]        bidx_q, bidx_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [POP_LAT-1:0] sr_q, sr_d;
  logic              permit_q, permit_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              run, bvalid, last_byte, last_word, hs, pop, accept;
  logic [DATA_W-1:0] head_word;
  logic [IW-1:0]     bsel;
  int                infl;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run       = (state_q == ST_RUN);
  assign bvalid    = run && (occ_q != '0);
  assign last_byte = (bidx_q == amt_q - 5'd1);
  assign last_word = (wcnt_q == npops_q - 16'd1);
  assign hs        = bvalid && i_byte_ready;
  assign pop       = hs && last_byte;
  // Words arriving outside a frame, into a full buffer, or beyond npops are dropped.
  assign accept    = PopEnable && run && (occ_q != OW'(DEPTH)) && (rcvd_q != npops_q);
  assign head_word = mem_q[rd_ptr_q];
  assign bsel      = IW'({bidx_q, 3'b000});

  always_comb begin
    state_d  = state_q;
    amt_d    = amt_q;
    npops_d  = npops_q;
    rcvd_d   = rcvd_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + OW'(accept) - OW'(pop);
    mem_d    = mem_q;
    err_d    = err_q | (PopEnable & ~accept);
    done_d   = 1'b0;
    sr_d     = POP_LAT'({sr_q, permit_q});
    infl     = $countones(sr_d);

    if (accept) begin
      mem_d[wr_ptr_q] = PopData;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      rcvd_d          = rcvd_q + 16'd1;
    end

    if (hs) begin
      if (last_byte) begin
        bidx_d   = '0;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        wcnt_d   = wcnt_q + 16'd1;
        if (last_word) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        bidx_d = bidx_q + 5'd1;
      end
    end

    // Permits still in flight and the word landing now both reserve a slot.
    permit_d = run
            && ((DEPTH - int'(occ_q) - infl - int'(PopEnable)) >= 1)
            && ((int'(rcvd_d) + infl) < int'(npops_q));

    if (!run && i_start) begin
      amt_d   = i_pop_amount;
      npops_d = i_num_pops;
      if ((i_pop_amount == 5'd0) || (i_num_pops == 16'd0)) begin
        done_d = 1'b1;
      end else begin
        state_d  = ST_RUN;
        rcvd_d   = '0;
        wcnt_d   = '0;
        bidx_d   = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        occ_d    = '0;
      end
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q  <= ST_IDLE;
      amt_q    <= '0;
      npops_q  <= '0;
      rcvd_q   <= '0;
      wcnt_q   <= '0;
      bidx_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sr_q     <= '0;
      permit_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      amt_q    <= amt_d;
      npops_q  <= npops_d;
      rcvd_q   <= rcvd_d;
      wcnt_q   <= wcnt_d;
      bidx_q   <= bidx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sr_q     <= sr_d;
      permit_q <= permit_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

`ifdef POP_READER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    word_cnt_d  = word_cnt_q;
    if (!run && i_start) begin
      stall_cnt_d = '0;
      word_cnt_d  = '0;
    end else begin
      if (bvalid && !i_byte_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (accept && (word_cnt_q != 16'hFFFF)) word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      stall_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_word_cnt  = word_cnt_q;
`endif

  assign PopPermit    = permit_q;
  assign PopAmout     = amt_q;
  assign o_byte       = head_word[bsel +: 8];
  assign o_byte_valid = bvalid;
  assign o_last       = bvalid && last_byte && last_word;
  assign o_busy       = run;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule
